// File: rtl/dac_pkg.sv
// dac_writer shared types: frame sizing, FSM states, DAC command codes.
// Optional load strobe is enabled with the DAC_LDAC_EN macro.
package dac_pkg;

  function automatic int frame_bits(
    input int cmd_bits,
    input int dac_bits
  );
    return cmd_bits + dac_bits;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GUARD = 2'd2
  } dac_st_e;

  localparam logic [3:0] CMD_WRITE        = 4'h0;
  localparam logic [3:0] CMD_WRITE_UPDATE = 4'h3;
  localparam logic [3:0] CMD_POWERDOWN    = 4'h4;

endpackage

// File: rtl/dac_if.sv
// go/state handshake shared with the ADC reader, plus the DAC word.
// Sequencer side is master, dac_writer is slave.
interface dac_if #(
  parameter int CMD_BITS = 4,
  parameter int DAC_BITS = 12
);
  logic                go;
  logic [CMD_BITS-1:0] cmd_i;
  logic [DAC_BITS-1:0] data_i;
  logic                state;
  logic                done;

  modport master (
    output go, cmd_i, data_i,
    input  state, done
  );

  modport slave (
    input  go, cmd_i, data_i,
    output state, done
  );
endinterface

// File: rtl/spi_clkgen.sv
// SPI mode-0 clock generator: sclk toggles every CLKDIV clkin edges
// while en is high; rise/fall flag the edge that will toggle it.
module spi_clkgen #(
  parameter int CLKDIV = 1
) (
  input  logic clkin,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);
  localparam int HW = $clog2(CLKDIV + 1);
  localparam logic [HW-1:0] HMAX = HW'(CLKDIV - 1);

  logic [HW-1:0] hcnt;
  logic          tick;

  assign tick = en && (hcnt == HMAX);
  assign rise = tick && !sclk;
  assign fall = tick && sclk;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      hcnt <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      hcnt <= '0;
      sclk <= ~sclk;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end
endmodule

// File: rtl/dac_writer.sv
// Write-only SPI master sending one {cmd, data} frame to a serial DAC.
// Define DAC_LDAC_EN to add the active-low ldac strobe after each frame.
module dac_writer
  import dac_pkg::*;
#(
  parameter int DAC_BITS = 12,
  parameter int CMD_BITS = 4,
  parameter int CLKDIV   = 1,
  parameter int CS_IDLE  = 2
) (
  input  logic clkin,
  input  logic rst,
  dac_if.slave bus,
  output logic sclk,
  output logic mosi,
  output logic cs
`ifdef DAC_LDAC_EN
  ,
  output logic ldac
`endif
);
  localparam int F  = frame_bits(CMD_BITS, DAC_BITS);
  localparam int BW = $clog2(F);
  localparam int GW = $clog2(CS_IDLE + 1);
  localparam logic [BW-1:0] BMAX = BW'(F - 1);
  localparam logic [GW-1:0] GMAX = GW'(CS_IDLE - 1);

  dac_st_e       st, st_n;
  logic [F-1:0]  sh, sh_n, word;
  logic [BW-1:0] bc, bc_n;
  logic [GW-1:0] gc, gc_n;
  logic          mosi_n, cs_n;
  logic          done_q, done_n;
  logic          rise, fall;

  assign word      = {bus.cmd_i, bus.data_i};
  assign bus.state = (st != IDLE);
  assign bus.done  = done_q;

  spi_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
    .clkin (clkin),
    .rst   (rst),
    .en    (st == SHIFT),
    .sclk  (sclk),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      sh     <= '0;
      bc     <= '0;
      gc     <= '0;
      mosi   <= 1'b0;
      cs     <= 1'b1;
      done_q <= 1'b0;
    end else begin
      st     <= st_n;
      sh     <= sh_n;
      bc     <= bc_n;
      gc     <= gc_n;
      mosi   <= mosi_n;
      cs     <= cs_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    st_n   = st;
    sh_n   = sh;
    bc_n   = bc;
    gc_n   = gc;
    mosi_n = mosi;
    cs_n   = cs;
    done_n = 1'b0;
    unique case (st)
      IDLE: begin
        if (bus.go) begin
          st_n   = SHIFT;
          sh_n   = word;
          mosi_n = word[F-1];
          cs_n   = 1'b0;
          bc_n   = BMAX;
        end
      end
      SHIFT: begin
        unique case (1'b1)
          fall: begin
            if (bc == '0) begin
              st_n   = GUARD;
              cs_n   = 1'b1;
              mosi_n = 1'b0;
              gc_n   = '0;
            end else begin
              sh_n   = sh << 1;
              mosi_n = sh_n[F-1];
              bc_n   = bc - 1'b1;
            end
          end
          rise:    mosi_n = mosi;
          default: ;
        endcase
      end
      GUARD: begin
        if (gc == GMAX) begin
          st_n   = IDLE;
          done_n = 1'b1;
        end else begin
          gc_n = gc + 1'b1;
        end
      end
      default: st_n = IDLE;
    endcase
  end

`ifdef DAC_LDAC_EN
  // one-cycle low pulse on the first guard edge, cs already high
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) ldac <= 1'b1;
    else     ldac <= !((st == GUARD) && (gc == '0));
  end
`endif
endmodule

// File: doc/dac_writer.md
Name: dac_writer

Overview:
- SPI master that writes one command+data frame to an external serial DAC.
- Output-side counterpart of the ADC sample reader; shares its go/state handshake so the same sequencer drives both.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first, active-low chip select, write-only (no MISO).

Parameters:
- DAC_BITS, 12: data bits per frame.
- CMD_BITS, 4: command/address bits, sent before the data.
- CLKDIV, 1: clkin cycles per sclk half-period (>=1).
- CS_IDLE, 2: clkin cycles cs stays high after a frame before the block accepts the next go (>=2).

Ports:
- clkin  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- go  input  1  start request; sampled only while idle.
- cmd_i  input  CMD_BITS  command field; latched on go.
- data_i  input  DAC_BITS  data field; latched on go.
- state  output  1  0=idle, 1=busy (shifting or guard).
- done  output  1  one-cycle pulse at frame completion.
- sclk  output  1  SPI clock.
- mosi  output  1  SPI data out.
- cs  output  1  chip select, active low.
- ldac  output  1  load-DAC strobe, active low; present only with DAC_LDAC_EN.

Behaviour:
- Frame: F = CMD_BITS+DAC_BITS (16 by default). Shift word = {cmd_i, data_i}, MSB first.
- Reset (async, any time, including mid-frame): sclk=0, mosi=0, cs=1, state=0, done=0, ldac=1. Shifter and counters are cleared and any frame in progress is aborted.
- FSM states: IDLE -> SHIFT -> GUARD -> IDLE.
- IDLE: state=0, cs=1, sclk=0.
  - Edge E0 is the edge that samples go=1.
  - At E0: latch the word, cs=0, mosi=bit F-1, sclk=0, state=1, half-period counter=0, bit counter=F-1, go to SHIFT.
- SHIFT: every CLKDIV edges, sclk toggles.
  - Rising sclk: the slave samples mosi; mosi is held.
  - Falling sclk: mosi advances to the next lower bit and the bit counter decrements.
  - Bit n (n=0 is the MSB) rises at edge E0+(2n+1)*CLKDIV and falls at E0+(2n+2)*CLKDIV.
  - On the fall of the last bit (edge E0+2F*CLKDIV): cs=1, mosi=0, go to GUARD.
  - Exactly F rising edges occur per frame. sclk is 0 whenever cs changes.
- GUARD: cs=1, state=1 for CS_IDLE cycles.
  - On the last guard edge: state=0, done=1 for one cycle, go to IDLE.
  - Total go-to-done latency = 2F*CLKDIV + CS_IDLE edges (34 with the defaults).
- go while state=1 is ignored and not queued. go held high re-triggers on the first IDLE edge after done. done and the new frame's cs=0 may coincide.
- cmd_i/data_i changes after E0 have no effect on the frame in flight.
- Counter widths: bit counter = clog2(F), half-period counter = clog2(CLKDIV+1), guard counter = clog2(CS_IDLE+1). No wrap is reachable in normal operation.

Optional Feature:
- Macro: DAC_LDAC_EN.
- Defined:
  - ldac port exists, reset value 1.
  - ldac=0 for exactly one clkin cycle, starting at the edge after cs rises (E0+2F*CLKDIV+1), then returns to 1. This always falls inside GUARD because CS_IDLE >= 2.
  - Reset during the pulse forces ldac=1.
- Undefined: no ldac port and no related logic. The board ties LDAC low, so the DAC updates on the cs rising edge.

Decomposition:
- Package dac_pkg holds:
  - FRAME_BITS derivation and FSM state encodings (IDLE=2'd0, SHIFT=2'd1, GUARD=2'd2).
  - DAC command codes: CMD_WRITE=4'h0, CMD_WRITE_UPDATE=4'h3, CMD_POWERDOWN=4'h4.
- One natural sub-module: spi_clkgen.
  - Half-period counter producing tick, sclk and rise/fall strobes, enabled only in SHIFT.
  - Reusable by the ADC reader.

Test Plan:
- Reset, then cmd=4'h3, data=12'hA5C, go pulse, CLKDIV=1 -> exactly 16 sclk rises, mosi captured on rises = 16'h3A5C, cs low from E0 to E0+32, done at E0+34.
- CLKDIV=3, word 16'hFFFF then 16'h0001 -> sclk high/low for 3 cycles each, cs low 96 cycles; second frame ends with mosi=1 only on the last rise.
- go pulsed at E0+10 while busy; go held high continuously -> mid-frame pulse ignored; held go yields back-to-back frames with cs high >= CS_IDLE cycles between them.
- rst asserted at E0+15, mid-frame -> cs=1, sclk=0, mosi=0, state=0 immediately (async); after release, the next go sends the full new frame.
- data_i changed from 12'h123 to 12'hFFF one cycle after E0 -> shifted word still carries 12'h123.
- With DAC_LDAC_EN -> ldac=0 only at cycle E0+33 (defaults), one cycle wide; without the macro the bench compiles with no ldac port.
